alu_ex_stage: RTL and testbench
===============================

Name: alu_ex_stage

Overview:
Execute-stage ALU plus EX/MEM pipeline register. It consumes the 4-bit ALU control code from the ALU control unit, together with the ID/EX operands and control bits, and performs the operation. Results, flags and forwarded control are registered for the MEM stage. It also latches arithmetic-overflow and illegal-op exceptions, with EPC capture, for the hazard/exception logic.

Parameters:
WIDTH, 32, datapath width of operands and result
REGADDR, 5, register-file address width

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (0 = reset)
stall  in  1  hold EX/MEM contents
flush  in  1  insert bubble into EX/MEM
inValid  in  1  ID/EX slot holds a real instruction
aluCtrl  in  4  ALU control code
opA  in  WIDTH  operand A (post-forwarding)
opB  in  WIDTH  operand B (post-forwarding / immediate)
pcIn  in  WIDTH  PC of the instruction in EX
rdIn  in  REGADDR  destination register
regWriteIn, memReadIn, memWriteIn, memToRegIn  in  1 each  control bits from ID/EX
writeDataIn  in  WIDTH  store data
trapEn  in  1  overflow trapping enabled for this instruction (add/sub, not addu/subu)
excAck  in  1  exception handler acknowledges pending exception
outValid  out  1  EX/MEM slot valid
aluResult  out  WIDTH  registered result
zero  out  1  registered (result == 0)
rdOut  out  REGADDR
regWriteOut, memReadOut, memWriteOut, memToRegOut  out  1 each
writeDataOut  out  WIDTH
ovfTrap  out  1  one-cycle pulse: trapped overflow this cycle
illegalOp  out  1  one-cycle pulse: invalid aluCtrl on a valid instruction
excPending  out  1  sticky exception-pending flag
epc  out  WIDTH  PC of the first unacknowledged excepting instruction

Behaviour:
- All state updates on rising clock. Priority: reset > flush > stall > load.
- reset=0: every output = 0, including epc and excPending. FSM enters IDLE.
- flush=1: outValid, all four control outputs, ovfTrap and illegalOp = 0. Data registers hold. Exception FSM is unaffected.
- stall=1 (no flush): every EX/MEM register holds. Pulses ovfTrap/illegalOp = 0. No new exception is captured.
- Load: outValid <= inValid. Data and control are captured. Latency is 1 cycle from inputs to outputs.
- Operations:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (A-B)
  - 0111 SLT (signed; result 1 or 0, zero-extended)
  - 1100 NOR
- Any other code, including 1111: result 0. illegalOp = inValid. Write/mem controls forced to 0.
- Arithmetic is modulo 2^WIDTH. zero is computed on the final registered result.
- Overflow:
  - ADD: sign(A) == sign(B) and sign(R) != sign(A).
  - SUB: sign(A) != sign(B) and sign(R) != sign(A).
  - Other ops never overflow.
- Trapped overflow = inValid & trapEn & overflow. It asserts ovfTrap and forces regWriteOut, memReadOut and memWriteOut to 0. Result is still registered.
- If inValid=0: controls are loaded but gated to 0. No flags are raised.
- Exception FSM, states IDLE and PENDING; excPending = (state == PENDING).
  - IDLE, new exception (trapped overflow or illegal op on load): epc <= pcIn, go to PENDING.
  - PENDING, excAck=1 and no new exception: go to IDLE, epc holds.
  - PENDING, new exception: stay in PENDING, epc NOT overwritten (first exception wins).
  - PENDING, excAck=1 and new exception in the same cycle: stay in PENDING, epc <= pcIn (set wins, new PC captured).
  - excAck in IDLE: no effect.
- Reset mid-exception returns to IDLE with epc = 0.

Decomposition:
- Shared package: ALU control code constants (ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_SLT=0111, ALU_NOR=1100, ALU_BAD=1111) and exception FSM state encodings. The ALU control unit uses the same package.
- One combinational sub-module, alu_core: inputs aluCtrl, opA, opB; outputs result, overflow, illegal. alu_ex_stage holds the registers, gating and FSM.

Test Plan:
- Reset: reset=0 for 2 cycles with random inputs -> all outputs 0; release, inValid=0 -> outValid=0.
- ADD/SUB/SLT: 0x00000005+0x00000003 -> aluResult=8, zero=0. SUB 7-7 -> 0, zero=1. SLT 0xFFFFFFFF vs 1 -> 1. All appear 1 cycle after inputs.
- Overflow: ADD 0x7FFFFFFF+1, trapEn=1, regWriteIn=1, pcIn=0x40 -> aluResult=0x80000000, ovfTrap=1, regWriteOut=0, excPending=1, epc=0x40. Same with trapEn=0 -> no trap, regWriteOut=1.
- Illegal/first-wins: aluCtrl=1111 at pc 0x10, then overflow at pc 0x14 -> illegalOp pulse, epc stays 0x10. excAck together with a new exception at pc 0x18 -> excPending=1, epc=0x18.
- Stall/flush: load AND 0xF0F0 & 0x0FF0 -> 0x00F0; stall=1 for 3 cycles with new inputs -> outputs unchanged. flush=1 together with stall -> outValid=0, controls 0.
- Reset mid-exception: excPending=1, then reset=0 -> excPending=0, epc=0.

Source files
------------

// File: rtl/alu_ex_stage_pkg.sv
// Shared ALU control codes and exception FSM encodings for the execute stage.
package alu_ex_stage_pkg;

    localparam int unsigned ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'b1100;
    localparam logic [ALU_CTRL_W-1:0] ALU_BAD = 4'b1111;

    typedef enum logic {
        EXC_IDLE    = 1'b0,
        EXC_PENDING = 1'b1
    } exc_state_e;

endpackage

// File: rtl/alu_ex_stage_alu_core.sv
// Combinational ALU: result, signed overflow for ADD/SUB, and illegal-code detect.
module alu_core
    import alu_ex_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [ALU_CTRL_W-1:0] aluCtrl,
    input  logic [WIDTH-1:0]      opA,
    input  logic [WIDTH-1:0]      opB,
    output logic [WIDTH-1:0]      result,
    output logic                  overflow,
    output logic                  illegal
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             a_s;
    logic             b_s;

    assign sum  = opA + opB;
    assign diff = opA - opB;
    assign a_s  = opA[WIDTH-1];
    assign b_s  = opB[WIDTH-1];

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (aluCtrl)
            ALU_AND: result = opA & opB;
            ALU_OR:  result = opA | opB;
            ALU_ADD: begin
                result   = sum;
                overflow = (a_s == b_s) && (sum[WIDTH-1] != a_s);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = (a_s != b_s) && (diff[WIDTH-1] != a_s);
            end
            ALU_SLT: result = WIDTH'($signed(opA) < $signed(opB));
            ALU_NOR: result = ~(opA | opB);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ex_stage.sv
// Execute-stage ALU with EX/MEM pipeline register and first-wins exception/EPC capture.
module alu_ex_stage
    import alu_ex_stage_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned REGADDR = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  inValid,
    input  logic [ALU_CTRL_W-1:0] aluCtrl,
    input  logic [WIDTH-1:0]      opA,
    input  logic [WIDTH-1:0]      opB,
    input  logic [WIDTH-1:0]      pcIn,
    input  logic [REGADDR-1:0]    rdIn,
    input  logic                  regWriteIn,
    input  logic                  memReadIn,
    input  logic                  memWriteIn,
    input  logic                  memToRegIn,
    input  logic [WIDTH-1:0]      writeDataIn,
    input  logic                  trapEn,
    input  logic                  excAck,
    output logic                  outValid,
    output logic [WIDTH-1:0]      aluResult,
    output logic                  zero,
    output logic [REGADDR-1:0]    rdOut,
    output logic                  regWriteOut,
    output logic                  memReadOut,
    output logic                  memWriteOut,
    output logic                  memToRegOut,
    output logic [WIDTH-1:0]      writeDataOut,
    output logic                  ovfTrap,
    output logic                  illegalOp,
    output logic                  excPending,
    output logic [WIDTH-1:0]      epc
);

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_ill;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .aluCtrl  (aluCtrl),
        .opA      (opA),
        .opB      (opB),
        .result   (alu_res),
        .overflow (alu_ovf),
        .illegal  (alu_ill)
    );

    logic               valid_q,     valid_d;
    logic [WIDTH-1:0]   result_q,    result_d;
    logic               zero_q,      zero_d;
    logic [REGADDR-1:0] rd_q,        rd_d;
    logic               reg_write_q, reg_write_d;
    logic               mem_read_q,  mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic               mem_to_reg_q, mem_to_reg_d;
    logic [WIDTH-1:0]   wdata_q,     wdata_d;
    logic               ovf_trap_q,  ovf_trap_d;
    logic               illegal_q,   illegal_d;
    logic [WIDTH-1:0]   epc_q,       epc_d;
    exc_state_e         state_q,     state_d;

    logic load;
    logic trap_now;
    logic ill_now;
    logic exc_new;

    assign load     = !flush && !stall;
    assign trap_now = inValid && trapEn && alu_ovf;
    assign ill_now  = inValid && alu_ill;
    assign exc_new  = load && (trap_now || ill_now);

    // EX/MEM register next-state: flush clears valid/controls/pulses, stall holds.
    always_comb begin
        valid_d      = valid_q;
        result_d     = result_q;
        zero_d       = zero_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        wdata_d      = wdata_q;
        ovf_trap_d   = 1'b0;
        illegal_d    = 1'b0;
        if (flush) begin
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
        end else if (!stall) begin
            valid_d      = inValid;
            result_d     = alu_res;
            zero_d       = (alu_res == '0);
            rd_d         = rdIn;
            wdata_d      = writeDataIn;
            reg_write_d  = inValid && regWriteIn && !ill_now && !trap_now;
            mem_read_d   = inValid && memReadIn  && !ill_now && !trap_now;
            mem_write_d  = inValid && memWriteIn && !ill_now && !trap_now;
            mem_to_reg_d = inValid && memToRegIn && !ill_now;
            ovf_trap_d   = trap_now;
            illegal_d    = ill_now;
        end
    end

    // Exception FSM: first exception wins unless acknowledged in the same cycle.
    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        case (state_q)
            EXC_IDLE: begin
                if (exc_new) begin
                    epc_d   = pcIn;
                    state_d = EXC_PENDING;
                end
            end
            EXC_PENDING: begin
                if (exc_new && excAck) begin
                    epc_d = pcIn;
                end else if (excAck) begin
                    state_d = EXC_IDLE;
                end
            end
            default: state_d = EXC_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            wdata_q      <= '0;
            ovf_trap_q   <= 1'b0;
            illegal_q    <= 1'b0;
            epc_q        <= '0;
            state_q      <= EXC_IDLE;
        end else begin
            valid_q      <= valid_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            wdata_q      <= wdata_d;
            ovf_trap_q   <= ovf_trap_d;
            illegal_q    <= illegal_d;
            epc_q        <= epc_d;
            state_q      <= state_d;
        end
    end

    assign outValid     = valid_q;
    assign aluResult    = result_q;
    assign zero         = zero_q;
    assign rdOut        = rd_q;
    assign regWriteOut  = reg_write_q;
    assign memReadOut   = mem_read_q;
    assign memWriteOut  = mem_write_q;
    assign memToRegOut  = mem_to_reg_q;
    assign writeDataOut = wdata_q;
    assign ovfTrap      = ovf_trap_q;
    assign illegalOp    = illegal_q;
    assign excPending   = (state_q == EXC_PENDING);
    assign epc          = epc_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Table-driven, scoreboarded bench for alu_ex_stage.
module tb_alu_ex_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall, flush, inValid;
    logic [3:0]  aluCtrl;
    logic [31:0] opA, opB, pcIn;
    logic [4:0]  rdIn;
    logic        regWriteIn, memReadIn, memWriteIn, memToRegIn;
    logic [31:0] writeDataIn;
    logic        trapEn, excAck;
    logic        outValid;
    logic [31:0] aluResult;
    logic        zero;
    logic [4:0]  rdOut;
    logic        regWriteOut, memReadOut, memWriteOut, memToRegOut;
    logic [31:0] writeDataOut;
    logic        ovfTrap, illegalOp, excPending;
    logic [31:0] epc;

    int n_cmp = 0;
    int n_bad = 0;

    alu_ex_stage #(.WIDTH(32), .REGADDR(5)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .inValid(inValid), .aluCtrl(aluCtrl), .opA(opA), .opB(opB),
        .pcIn(pcIn), .rdIn(rdIn), .regWriteIn(regWriteIn),
        .memReadIn(memReadIn), .memWriteIn(memWriteIn), .memToRegIn(memToRegIn),
        .writeDataIn(writeDataIn), .trapEn(trapEn), .excAck(excAck),
        .outValid(outValid), .aluResult(aluResult), .zero(zero), .rdOut(rdOut),
        .regWriteOut(regWriteOut), .memReadOut(memReadOut),
        .memWriteOut(memWriteOut), .memToRegOut(memToRegOut),
        .writeDataOut(writeDataOut), .ovfTrap(ovfTrap), .illegalOp(illegalOp),
        .excPending(excPending), .epc(epc)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        stall, flush, vld;
        logic [3:0]  ctrl;
        logic [31:0] a, b, pc;
        logic        trap_en, rw_in, ack;
    } stim_t;

    typedef struct {
        logic        vld;
        logic [31:0] res;
        logic        z, ovf, ill, rw, pend;
        logic [31:0] epc;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s vec=%0d actual=0x%08h required=0x%08h", name, idx, act, req);
        end
    endtask

    task automatic add(input logic st, input logic fl, input logic v, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                       input logic te, input logic rw, input logic ack,
                       input logic ev, input logic [31:0] er, input logic ez, input logic eo,
                       input logic ei, input logic erw, input logic ep, input logic [31:0] eepc);
        vec_t x;
        x.s = '{stall: st, flush: fl, vld: v, ctrl: c, a: a, b: b, pc: pc, trap_en: te, rw_in: rw, ack: ack};
        x.e = '{vld: ev, res: er, z: ez, ovf: eo, ill: ei, rw: erw, pend: ep, epc: eepc};
        vecs.push_back(x);
    endtask

    initial begin
        exp_t e;
        // reset with random inputs for two cycles
        reset = 1'b0; stall = 1'b0; flush = 1'b0; excAck = 1'b0;
        memReadIn = 1'b0; memToRegIn = 1'b0; rdIn = 5'd3;
        for (int i = 0; i < 2; i++) begin
            inValid = 1'($urandom); aluCtrl = 4'($urandom); opA = $urandom; opB = $urandom;
            pcIn = $urandom; regWriteIn = 1'($urandom); memWriteIn = regWriteIn;
            writeDataIn = $urandom; trapEn = 1'($urandom);
            @(posedge clock); #1;
        end
        check("rst_valid", -1, 32'(outValid), 0);
        check("rst_result", -1, aluResult, 0);
        check("rst_zero", -1, 32'(zero), 0);
        check("rst_ctrl", -1, 32'({regWriteOut, memReadOut, memWriteOut, memToRegOut}), 0);
        check("rst_rd_wd", -1, 32'(rdOut) | writeDataOut, 0);
        check("rst_flags", -1, 32'({ovfTrap, illegalOp, excPending}), 0);
        check("rst_epc", -1, epc, 0);
        reset = 1'b1;

        //  st fl v ctrl      a             b             pc     te rw ack | v res           z o i rw p epc
        add(0, 0, 0, 4'b0010, 32'd1,        32'd1,        32'h00, 0, 1, 0,  0, 32'd2,        0, 0, 0, 0, 0, 32'h00);
        add(0, 0, 1, 4'b0010, 32'd5,        32'd3,        32'h04, 1, 1, 0,  1, 32'd8,        0, 0, 0, 1, 0, 32'h00);
        add(0, 0, 1, 4'b0110, 32'd7,        32'd7,        32'h08, 1, 1, 0,  1, 32'd0,        1, 0, 0, 1, 0, 32'h00);
        add(0, 0, 1, 4'b0111, 32'hFFFFFFFF, 32'd1,        32'h0C, 0, 1, 0,  1, 32'd1,        0, 0, 0, 1, 0, 32'h00);
        add(0, 0, 1, 4'b0001, 32'hF0,       32'h0F,       32'h0C, 0, 1, 0,  1, 32'hFF,       0, 0, 0, 1, 0, 32'h00);
        add(0, 0, 1, 4'b1100, 32'h0,        32'h0,        32'h0C, 0, 1, 0,  1, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 32'h00);
        add(0, 0, 1, 4'b0010, 32'h7FFFFFFF, 32'd1,        32'h3C, 0, 1, 0,  1, 32'h80000000, 0, 0, 0, 1, 0, 32'h00);
        add(0, 0, 1, 4'b0010, 32'h7FFFFFFF, 32'd1,        32'h40, 1, 1, 0,  1, 32'h80000000, 0, 1, 0, 0, 1, 32'h40);
        add(0, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h44, 0, 0, 1,  0, 32'h0,        1, 0, 0, 0, 0, 32'h40);
        // first exception wins, then ack together with a new one captures the new PC
        add(0, 0, 1, 4'b1111, 32'd5,        32'd5,        32'h10, 0, 1, 0,  1, 32'h0,        1, 0, 1, 0, 1, 32'h10);
        add(0, 0, 1, 4'b0110, 32'h80000000, 32'd1,        32'h14, 1, 1, 0,  1, 32'h7FFFFFFF, 0, 1, 0, 0, 1, 32'h10);
        add(0, 0, 1, 4'b0011, 32'd9,        32'd9,        32'h18, 0, 1, 1,  1, 32'h0,        1, 0, 1, 0, 1, 32'h18);
        add(0, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h1C, 0, 0, 1,  0, 32'h0,        1, 0, 0, 0, 0, 32'h18);
        // stall holds, stall+flush bubbles without touching data
        add(0, 0, 1, 4'b0000, 32'hF0F0,     32'h0FF0,     32'h20, 0, 1, 0,  1, 32'h00F0,     0, 0, 0, 1, 0, 32'h18);
        add(1, 0, 1, 4'b0010, 32'h7FFFFFFF, 32'd1,        32'h24, 1, 1, 0,  1, 32'h00F0,     0, 0, 0, 1, 0, 32'h18);
        add(1, 0, 1, 4'b1111, 32'd3,        32'd4,        32'h28, 1, 0, 0,  1, 32'h00F0,     0, 0, 0, 1, 0, 32'h18);
        add(1, 0, 1, 4'b0001, 32'h1,        32'h2,        32'h2C, 0, 0, 0,  1, 32'h00F0,     0, 0, 0, 1, 0, 32'h18);
        add(1, 1, 1, 4'b0001, 32'h1,        32'h2,        32'h2C, 0, 1, 0,  0, 32'h00F0,     0, 0, 0, 0, 0, 32'h18);
        add(0, 0, 1, 4'b0110, 32'h80000000, 32'd1,        32'h30, 0, 1, 0,  1, 32'h7FFFFFFF, 0, 0, 0, 1, 0, 32'h18);
        add(0, 0, 1, 4'b0010, 32'hFFFFFFFF, 32'd1,        32'h34, 1, 1, 0,  1, 32'h0,        1, 0, 0, 1, 0, 32'h18);
        add(0, 0, 1, 4'b0010, 32'h80000000, 32'h80000000, 32'h50, 1, 1, 0,  1, 32'h0,        1, 1, 0, 0, 1, 32'h50);

        for (int i = 0; i < vecs.size(); i++) begin
            stall = vecs[i].s.stall; flush = vecs[i].s.flush; inValid = vecs[i].s.vld;
            aluCtrl = vecs[i].s.ctrl; opA = vecs[i].s.a; opB = vecs[i].s.b; pcIn = vecs[i].s.pc;
            trapEn = vecs[i].s.trap_en; regWriteIn = vecs[i].s.rw_in; memWriteIn = vecs[i].s.rw_in;
            excAck = vecs[i].s.ack; rdIn = 5'(i); writeDataIn = 32'hA000 + 32'(i);
            sb.push_back(vecs[i].e);
            @(posedge clock); #1;
            e = sb.pop_front();
            check("valid", i, 32'(outValid), 32'(e.vld));
            check("result", i, aluResult, e.res);
            check("zero", i, 32'(zero), 32'(e.z));
            check("ovfTrap", i, 32'(ovfTrap), 32'(e.ovf));
            check("illegalOp", i, 32'(illegalOp), 32'(e.ill));
            check("regWrite", i, 32'(regWriteOut), 32'(e.rw));
            check("memWrite", i, 32'(memWriteOut), 32'(e.rw));
            check("excPending", i, 32'(excPending), 32'(e.pend));
            check("epc", i, epc, e.epc);
        end
        check("rdOut_last", 20, 32'(rdOut), 32'd20);
        check("wdata_last", 20, writeDataOut, 32'hA014);

        // reset while an exception is pending
        stall = 1'b0; flush = 1'b0; excAck = 1'b0; inValid = 1'b1;
        reset = 1'b0;
        @(posedge clock); #1;
        check("midrst_pending", 99, 32'(excPending), 0);
        check("midrst_epc", 99, epc, 0);
        check("midrst_valid", 99, 32'(outValid), 0);
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
